ika2151_bus_writer: RTL
=======================

# ika2151_bus_writer

Host-side write sequencer for the IKA2151 CPU bus. It accepts register write requests (register address and data) through a valid/ready port and buffers them in a small FIFO. Each request is turned into the chip's two-phase bus cycle: an address write with A0=0, then a data write with A0=1, using programmable setup, strobe and recovery times. After every data write it holds off for a fixed busy interval. It sits between a soft CPU or ROM player and the IKA2151 `i_CS_n`/`i_WR_n`/`i_A0`/`i_D` pins, and replaces hand-timed bus tasks.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `SETUP_CYC`, 15: i_EMUCLK cycles with CS_n low and WR_n high before the strobe; ≥1.
- `PULSE_CYC`, 20: cycles with WR_n low; ≥1.
- `RECOV_CYC`, 15: cycles with CS_n high after each strobe; ≥1.
- `BUSY_CYC`, 256: hold-off cycles after the data-phase recovery (64 phiM cycles); 0 skips the wait.

Ports:
- `i_EMUCLK` in 1: the single clock; all logic is on the rising edge.
- `i_IC_n` in 1: asynchronous, active-low reset.
- `i_REQ_VALID` in 1: a write request is present.
- `i_REQ_ADDR` in 8: register address.
- `i_REQ_DATA` in 8: register data.
- `o_REQ_READY` out 1: the FIFO is not full.
- `o_CS_n` out 1: chip select to the IKA2151.
- `o_WR_n` out 1: write strobe.
- `o_A0` out 1: 0 for the address phase, 1 for the data phase.
- `o_D` out 8: bus data.
- `o_IDLE` out 1: the FIFO is empty and the FSM is in IDLE.
- `o_FIFO_CNT` out clog2(DEPTH)+1: number of occupied entries.

## Operation
- **Accept:** a request is accepted on an edge where `i_REQ_VALID & o_REQ_READY`.
  - `o_REQ_READY = (o_FIFO_CNT != DEPTH)`, combinational.
  - A push and a pop on the same edge are allowed; the count is unchanged.
  - When the FIFO is full there is no push, even if a pop occurs on that edge.
- **FSM states:** IDLE, A_SETUP, A_PULSE, A_RECOV, D_SETUP, D_PULSE, D_RECOV, BUSY.
- **Counter:** a 16-bit down-counter is loaded with N-1 on state entry; the state exits when the counter reaches 0, so each timed state lasts exactly N cycles.
- **IDLE:** when the FIFO is non-empty, pop the head entry into the working address and data registers.
  - Go to A_SETUP if the address cache is invalid or the cached address differs from the popped address.
  - Otherwise go to D_SETUP. This is the address skip, valid because the chip retains its address latch.
- **Sequence:** A_SETUP → A_PULSE → A_RECOV → D_SETUP → D_PULSE → D_RECOV → BUSY (or IDLE when BUSY_CYC=0) → IDLE.
- **Address cache:** on exit from A_PULSE, the cache is loaded with the working address and marked valid.
- **Outputs:** all outputs are registered.
  - `o_CS_n` is 0 only in the SETUP and PULSE states.
  - `o_WR_n` is 0 only in the PULSE states.
  - `o_A0` is 0 in the A_* states and 1 in the D_* states.
  - `o_D` carries the working address in the A_* states and the working data in the D_* states.
  - In IDLE and BUSY, `o_A0` and `o_D` hold their last values.
- **Reset values:** `o_CS_n`=1, `o_WR_n`=1, `o_A0`=0, `o_D`=0x00, FIFO empty, `o_FIFO_CNT`=0, FSM in IDLE, address cache invalid, `o_IDLE`=1, `o_REQ_READY`=1.
- **Reset mid-cycle:** asserting `i_IC_n` low at any point forces the reset values immediately, because the reset is asynchronous. A bus cycle in progress is abandoned and FIFO contents are discarded.

## Timing
- **Start latency:** a request accepted on edge k into an empty FIFO while the FSM is idle is popped on edge k+1. `o_CS_n` falls after edge k+1.
- **Address phase, relative to the CS_n fall:**
  - WR_n falls SETUP_CYC cycles later.
  - WR_n and CS_n rise together after a further PULSE_CYC cycles.
  - `o_D` and `o_A0` are stable from the CS_n fall until the next state change after recovery.
- **Full write:** with default parameters a write with an address phase occupies 2×(15+20+15)+256 = 356 cycles from the CS_n fall to the return to IDLE. A write that skips the address phase occupies 50+256 = 306 cycles.
- **Back-to-back:** the next pop happens on the edge after the FSM returns to IDLE. There is exactly one IDLE cycle between consecutive requests.
- **Pipelined accept:** the FIFO keeps accepting while a bus cycle is running.
- **`o_IDLE`:** registered, and asserted only when the FSM is in IDLE and `o_FIFO_CNT` is 0.

## Test plan
- **Single write after reset:** push (0x18, 0xFF) → CS_n falls 1 cycle after acceptance, A0=0, D=0x18. WR_n is low for 20 cycles starting 15 cycles after the CS_n fall. The data phase follows with A0=1, D=0xFF. `o_IDLE` returns 356 cycles after the CS_n fall.
- **Address skip:** push (0x28, 0x4A) then (0x28, 0x4B) → the second request has no A0=0 strobe and takes 306 cycles. A following (0x38, 0x70) performs a full address phase.
- **Cache invalid after reset:** reset, then push (0x00, 0x01) → the address phase is performed even though `o_D` reset to 0x00.
- **FIFO full:** with DEPTH=4, push 6 requests back-to-back → `o_REQ_READY` drops when 4 entries are queued and the first is in flight. All accepted writes appear on the bus in order. `o_FIFO_CNT` never exceeds 4.
- **Reset mid-strobe:** drop `i_IC_n` during D_PULSE → CS_n=1, WR_n=1, A0=0, D=0x00 immediately, and the FIFO count is 0. Queued writes never appear after reset is released.
- **BUSY_CYC=0:** two different-address writes → the second CS_n falls exactly 1 cycle after the first D_RECOV ends.

Source files
------------

// File: rtl/ika2151_bus_writer.sv
// IKA2151 host-side write sequencer: buffers register writes in a FIFO and replays each one
// as an address strobe (A0=0) followed by a data strobe (A0=1) with programmable timing.
module ika2151_bus_writer #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned SETUP_CYC = 15,
    parameter int unsigned PULSE_CYC = 20,
    parameter int unsigned RECOV_CYC = 15,
    parameter int unsigned BUSY_CYC  = 256
) (
    input  logic                   i_EMUCLK,
    input  logic                   i_IC_n,
    input  logic                   i_REQ_VALID,
    input  logic [7:0]             i_REQ_ADDR,
    input  logic [7:0]             i_REQ_DATA,
    output logic                   o_REQ_READY,
    output logic                   o_CS_n,
    output logic                   o_WR_n,
    output logic                   o_A0,
    output logic [7:0]             o_D,
    output logic                   o_IDLE,
    output logic [$clog2(DEPTH):0] o_FIFO_CNT
);

    localparam int unsigned PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL     = (PW + 1)'(DEPTH);
    localparam logic [15:0] SETUP_LD = 16'(SETUP_CYC - 1);
    localparam logic [15:0] PULSE_LD = 16'(PULSE_CYC - 1);
    localparam logic [15:0] RECOV_LD = 16'(RECOV_CYC - 1);
    localparam logic [15:0] BUSY_LD  = (BUSY_CYC == 0) ? 16'd0 : 16'(BUSY_CYC - 1);

    typedef enum logic [2:0] {
        StIdle, StASetup, StAPulse, StARecov, StDSetup, StDPulse, StDRecov, StBusy
    } state_e;

    // FIFO
    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   cnt_q, cnt_d;
    logic [15:0]   head;
    logic          push, pop;

    assign o_REQ_READY = (cnt_q != FULL);
    assign push        = i_REQ_VALID && o_REQ_READY;
    assign head        = mem[rptr_q];
    assign o_FIFO_CNT  = cnt_q;

    always_ff @(posedge i_EMUCLK) begin
        if (push) mem[wptr_q] <= {i_REQ_ADDR, i_REQ_DATA};
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
    end

    // Sequencer
    state_e      state_q, state_d;
    logic [15:0] tmr_q, tmr_d;
    logic [7:0]  addr_q, addr_d, data_q, data_d;
    logic [7:0]  cache_q, cache_d;
    logic        cache_vld_q, cache_vld_d;
    logic        cs_n_q, cs_n_d, wr_n_q, wr_n_d, a0_q, a0_d, idle_q, idle_d;
    logic [7:0]  d_q, d_d;

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cache_d     = cache_q;
        cache_vld_d = cache_vld_q;
        pop         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cnt_q != '0) begin
                    pop    = 1'b1;
                    addr_d = head[15:8];
                    data_d = head[7:0];
                    tmr_d  = SETUP_LD;
                    // The chip keeps its address latch, so a repeated address skips phase A.
                    if (!cache_vld_q || cache_q != head[15:8]) state_d = StASetup;
                    else                                       state_d = StDSetup;
                end
            end
            StASetup: begin
                if (tmr_q == '0) begin state_d = StAPulse; tmr_d = PULSE_LD; end
                else tmr_d = tmr_q - 16'd1;
            end
            StAPulse: begin
                if (tmr_q == '0) begin
                    state_d     = StARecov;
                    tmr_d       = RECOV_LD;
                    cache_d     = addr_q;
                    cache_vld_d = 1'b1;
                end else tmr_d = tmr_q - 16'd1;
            end
            StARecov: begin
                if (tmr_q == '0) begin state_d = StDSetup; tmr_d = SETUP_LD; end
                else tmr_d = tmr_q - 16'd1;
            end
            StDSetup: begin
                if (tmr_q == '0) begin state_d = StDPulse; tmr_d = PULSE_LD; end
                else tmr_d = tmr_q - 16'd1;
            end
            StDPulse: begin
                if (tmr_q == '0) begin state_d = StDRecov; tmr_d = RECOV_LD; end
                else tmr_d = tmr_q - 16'd1;
            end
            StDRecov: begin
                if (tmr_q == '0) begin
                    state_d = (BUSY_CYC == 0) ? StIdle : StBusy;
                    tmr_d   = BUSY_LD;
                end else tmr_d = tmr_q - 16'd1;
            end
            StBusy: begin
                if (tmr_q == '0) state_d = StIdle;
                else tmr_d = tmr_q - 16'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so the pins change on the same edge as the FSM.
    always_comb begin
        cs_n_d = !(state_d inside {StASetup, StAPulse, StDSetup, StDPulse});
        wr_n_d = !(state_d inside {StAPulse, StDPulse});
        a0_d   = a0_q;
        d_d    = d_q;
        if (state_d inside {StASetup, StAPulse, StARecov}) begin
            a0_d = 1'b0;
            d_d  = addr_d;
        end else if (state_d inside {StDSetup, StDPulse, StDRecov}) begin
            a0_d = 1'b1;
            d_d  = data_d;
        end
        idle_d = (state_d == StIdle) && (cnt_d == '0);
    end

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            state_q     <= StIdle;
            tmr_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            cache_q     <= '0;
            cache_vld_q <= 1'b0;
            cs_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            a0_q        <= 1'b0;
            d_q         <= '0;
            idle_q      <= 1'b1;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cache_q     <= cache_d;
            cache_vld_q <= cache_vld_d;
            cs_n_q      <= cs_n_d;
            wr_n_q      <= wr_n_d;
            a0_q        <= a0_d;
            d_q         <= d_d;
            idle_q      <= idle_d;
        end
    end

    assign o_CS_n = cs_n_q;
    assign o_WR_n = wr_n_q;
    assign o_A0   = a0_q;
    assign o_D    = d_q;
    assign o_IDLE = idle_q;

endmodule
